// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Instruction fetch initiator. It issues word-address reads to a
//   one-cycle-latency instruction memory and buffers the returned words in a
//   small FIFO. Decode sees the words over a valid/ready handshake, and each
//   word carries the PC it was fetched from. A redirect loads a new PC and
//   flushes both the buffered fetches and any fetch still in flight.
//
//   Ports
//     clock, reset         rising-edge clock, asynchronous active-low reset
//     fetch_en             permit issuing new fetches
//     mem_addr, mem_read   word address and read strobe to instruction memory
//     mem_inst             memory word, valid the cycle after mem_read
//     redirect_valid/_pc   load a new fetch PC and flush
//     inst_valid/_data/_pc FIFO head presented to decode
//     inst_ready           decode accepts the head
//
//   state | meaning
//   IDLE  | fetch_en low, no new reads issued; a pending response still lands
//   RUN   | fetch_en high, issue whenever the FIFO credit check allows
module inst_fetch_unit #(
    parameter int                 ADDR_W     = 27,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter int                 FIFO_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [31:0]       mem_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               pending_q, pending_d;
    logic [ADDR_W-1:0]  pending_pc_q, pending_pc_d;
    logic               pend_epoch_q, pend_epoch_d;
    logic               epoch_q, epoch_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]  fifo_pc_q   [FIFO_DEPTH];
    logic [31:0]        fifo_data_q [FIFO_DEPTH];

    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     credit;

    assign inst_valid = (count_q != '0);
    assign inst_data  = fifo_data_q[rd_ptr_q];
    assign inst_pc    = fifo_pc_q[rd_ptr_q];
    assign mem_addr   = fetch_pc_q;
    assign mem_read   = issue;

    assign pop  = inst_valid & inst_ready;
    // A response only lands if no redirect happened since its read issued.
    assign push = pending_q & (pend_epoch_q == epoch_q);

    // Slots already claimed after this cycle's pop; the pending read owns one,
    // so a push can never find the FIFO full.
    assign credit = {1'b0, count_q} + {{CNT_W{1'b0}}, pending_q} - {{CNT_W{1'b0}}, pop};

    // reset gates the strobe so it is low for the whole time reset is held.
    assign issue = reset & (state_d == RUN) & ~redirect_valid
                 & (credit < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_d    = 1'b0;
        pending_pc_d = pending_pc_q;
        pend_epoch_d = pend_epoch_q;
        epoch_d      = epoch_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            epoch_d    = ~epoch_q;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (issue) begin
                fetch_pc_d   = fetch_pc_q + ADDR_W'(1);
                pending_d    = 1'b1;
                pending_pc_d = fetch_pc_q;
                pend_epoch_d = epoch_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            pend_epoch_q <= 1'b0;
            epoch_q      <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            pend_epoch_q <= pend_epoch_d;
            epoch_q      <= epoch_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else if (push && !redirect_valid) begin
            fifo_pc_q[wr_ptr_q]   <= pending_pc_q;
            fifo_data_q[wr_ptr_q] <= mem_inst;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit
//   Randomized and directed bench for inst_fetch_unit. A queue-based model
//   of the fetch buffer predicts the strobe, address and decode-side outputs
//   every cycle. The memory responds with word[a] = a + 0x100.
module tb_inst_fetch_unit;

    localparam int ADDR_W = 27;
    localparam int DEPTH  = 2;

    logic              clock;
    logic              reset;
    logic              fetch_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic [31:0]       mem_inst;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    inst_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC('0), .FIFO_DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_inst       (mem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       data;
    } ent_t;

    ent_t              q[$];
    logic [ADDR_W-1:0] m_fpc;
    bit                m_pend;
    logic [ADDR_W-1:0] m_ppc;
    int                checks = 0;
    int                errors = 0;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        return {5'b0, a} + 32'h100;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven. Check outputs, cross the
    // edge, advance the model, then present the memory response.
    task automatic step();
        bit                pop;
        bit                exp_rd;
        bit                rd;
        logic [ADDR_W-1:0] addr;
        int                used;
        #1;
        pop    = (q.size() > 0) && inst_ready;
        used   = q.size() + int'(m_pend) - int'(pop);
        exp_rd = fetch_en && !redirect_valid && (used < DEPTH);
        check_val("mem_read", 64'(mem_read), 64'(exp_rd));
        check_val("mem_addr", 64'(mem_addr), 64'(m_fpc));
        check_val("inst_valid", 64'(inst_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check_val("inst_pc", 64'(inst_pc), 64'(q[0].pc));
            check_val("inst_data", 64'(inst_data), 64'(q[0].data));
        end
        check_val("push_into_full",
                  64'(dut.push && !dut.pop && !redirect_valid && (int'(dut.count_q) >= DEPTH)), 64'(0));
        rd   = mem_read;
        addr = mem_addr;
        @(posedge clock);
        if (redirect_valid) begin
            q.delete();
            m_pend = 0;
            m_fpc  = redirect_pc;
        end else begin
            if (pop) void'(q.pop_front());
            if (m_pend) q.push_back('{pc: m_ppc, data: word_of(m_ppc)});
            m_pend = exp_rd;
            if (exp_rd) begin
                m_ppc = m_fpc;
                m_fpc = m_fpc + 1'b1;
            end
        end
        #1;
        mem_inst = rd ? word_of(addr) : 32'hDEAD_BEEF;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check_val("rst_mem_read", 64'(mem_read), 64'(0));
        check_val("rst_mem_addr", 64'(mem_addr), 64'(0));
        check_val("rst_inst_valid", 64'(inst_valid), 64'(0));
        check_val("rst_inst_data", 64'(inst_data), 64'(0));
        check_val("rst_inst_pc", 64'(inst_pc), 64'(0));
        q.delete();
        m_pend = 0;
        m_fpc  = '0;
        m_ppc  = '0;
        @(posedge clock);
        #1;
        mem_inst = 32'hDEAD_BEEF;
        reset    = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset          = 1'b0;
        fetch_en       = 1'b0;
        mem_inst       = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        @(posedge clock);
        #1;
        pulse_reset();

        // Streaming from reset.
        fetch_en   = 1'b1;
        inst_ready = 1'b1;
        run(12);

        // Backpressure for 6 cycles.
        inst_ready = 1'b0;
        run(6);
        inst_ready = 1'b1;
        run(6);

        // Redirect while the buffer is full, then while a read is in flight.
        inst_ready = 1'b0;
        run(3);
        redirect_valid = 1'b1;
        redirect_pc    = 27'h40;
        step();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        run(3);
        redirect_valid = 1'b1;
        redirect_pc    = 27'h80;
        step();
        redirect_valid = 1'b0;
        run(6);

        // Address wrap.
        redirect_valid = 1'b1;
        redirect_pc    = 27'h7FF_FFFE;
        step();
        redirect_valid = 1'b0;
        run(8);

        // fetch_en dropped with a read pending.
        fetch_en = 1'b0;
        run(5);
        fetch_en = 1'b1;
        run(6);

        // Reset mid-stream with a pending read and a buffered word.
        pulse_reset();
        run(8);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            inst_ready     = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? 27'h7FF_FFFD : ADDR_W'($urandom());
            step();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        run(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
